// File: rtl/mdr_read_ctrl.sv
// MDR read side: latches MAR address, runs mem_req/mem_ack, captures data into MDR; bus MDRin loads when idle.
// Latency: read_start edge N -> mem_req after N, ack at edge >= N+2 -> MDR/done after that edge; no queueing, timeout -> err.
module mdr_read_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 9,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              read_start,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              MDRin,
    input  logic [DATA_W-1:0] bus_in,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] BusMuxIn_MDR,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [DATA_W-1:0] mdr_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              req_nxt, busy_nxt, done_nxt, err_nxt;

    // Every output is a flop loaded from the next-state decode, so none can glitch.
    always_ff @(posedge clk) begin
        if (clr) begin
            state        <= S_IDLE;
            cnt          <= '0;
            BusMuxIn_MDR <= '0;
            mem_addr     <= '0;
            mem_req      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            BusMuxIn_MDR <= mdr_nxt;
            mem_addr     <= addr_nxt;
            mem_req      <= req_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
            err          <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (read_start) state_nxt = S_REQ;
            end
            S_REQ: begin
                state_nxt = S_WAIT;
                cnt_nxt   = '0;
            end
            S_WAIT: begin
                // The counter is left at its last value on the way to ERR, so it never wraps.
                if (mem_ack)              state_nxt = S_DONE;
                else if (cnt == CNT_LAST) state_nxt = S_ERR;
                else                      cnt_nxt   = cnt + 1'b1;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mdr_nxt  = BusMuxIn_MDR;
        addr_nxt = mem_addr;
        err_nxt  = err;
        req_nxt  = (state_nxt == S_REQ) || (state_nxt == S_WAIT);
        busy_nxt = req_nxt;
        done_nxt = (state_nxt == S_DONE);

        // Memory capture wins; the bus load is only honoured outside a transaction.
        if (state == S_WAIT && mem_ack) begin
            mdr_nxt = mem_data;
        end else if (MDRin && (state == S_IDLE || state == S_DONE || state == S_ERR)) begin
            mdr_nxt = bus_in;
        end

        if (state == S_IDLE && read_start) begin
            addr_nxt = addr_in;
            err_nxt  = 1'b0;
        end
        if (state_nxt == S_ERR) err_nxt = 1'b1;
    end

endmodule
